trig_rom_arbiter: RTL and testbench



---
 rtl/trig_rom_arbiter_if.sv | 24 ++
 rtl/trig_rom_arbiter.sv | 176 +++++++++++++++++
 tb/tb_trig_rom_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trig_rom_arbiter_if.sv
// Request/response bundle between the angle requesters and the shared
// cosine-ROM arbiter.
interface trig_rom_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ANGLE_W = 16,
  parameter int unsigned DATA_W  = 16
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_func;
  logic [NUM_REQ*ANGLE_W-1:0] req_angle;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0]         resp_valid;
  logic [NUM_REQ*DATA_W-1:0]  resp_data;

  modport master (
    output req_valid, req_func, req_angle,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_func, req_angle,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/trig_rom_arbiter.sv
// Round-robin arbiter sharing one quarter-wave cosine ROM between several
// requesters; returns signed sin/cos of integer-degree angles per lane.
module trig_rom_arbiter #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned ANGLE_W   = 16,
  parameter int unsigned ROM_DEPTH = 64,
  parameter int unsigned ROM_WIDTH = 8,
  parameter int unsigned DATA_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  trig_rom_arbiter_if.slave            bus,
  output logic                         rom_en,
  output logic [$clog2(ROM_DEPTH)-1:0] rom_addr,
  input  logic [ROM_WIDTH-1:0]         rom_data
);

  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned AW = $clog2(ROM_DEPTH);
  localparam int unsigned TW = ANGLE_W + 1;
  localparam logic signed [TW-1:0] DEG90  = TW'(90);
  localparam logic signed [TW-1:0] DEG360 = TW'(360);

  typedef enum logic [2:0] {IDLE, NORM, READ, WAIT, RESP} state_e;

  state_e                      state_q, state_d;
  logic [GW-1:0]               last_q, last_d;
  logic [GW-1:0]               w_q, w_d;
  logic signed [TW-1:0]        theta_q, theta_d;
  logic                        neg_q, neg_d;
  logic                        rom_en_q, rom_en_d;
  logic [AW-1:0]               rom_addr_q, rom_addr_d;
  logic [NUM_REQ-1:0]          resp_valid_q, resp_valid_d;
  logic [NUM_REQ*DATA_W-1:0]   resp_data_q, resp_data_d;
  logic [NUM_REQ-1:0]          req_ready_c;

  logic                        win_found;
  logic [GW-1:0]               win_idx;
  int unsigned                 cand_c;

  logic [ANGLE_W-1:0]          ang_sel;
  logic signed [TW-1:0]        ang_ext;
  logic signed [TW-1:0]        theta_new;

  int unsigned                 th_c, x_c, q_c;
  logic                        quad_neg;
  logic [AW-1:0]               idx_c;

  logic [DATA_W-1:0]           mag_c, val_c;

  // Search starts just after the last served lane so every lane gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_c    = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand_c = 32'(last_q) + 1 + i;
      if (cand_c >= NUM_REQ) cand_c = cand_c - NUM_REQ;
      if (!win_found && bus.req_valid[GW'(cand_c)]) begin
        win_found = 1'b1;
        win_idx   = GW'(cand_c);
      end
    end
  end

  // sin(a) is served as cos(a - 90), so only a cosine table is needed.
  always_comb begin
    ang_sel   = bus.req_angle[win_idx*ANGLE_W +: ANGLE_W];
    ang_ext   = {ang_sel[ANGLE_W-1], ang_sel};
    theta_new = bus.req_func[win_idx] ? (ang_ext - DEG90) : ang_ext;
  end

  // Quadrant fold of a normalised angle into a 0..90 degree table offset.
  always_comb begin
    th_c     = 32'(theta_q[8:0]);
    x_c      = th_c;
    quad_neg = 1'b0;
    if (th_c < 90) begin
      x_c      = th_c;
      quad_neg = 1'b0;
    end else if (th_c < 180) begin
      x_c      = 180 - th_c;
      quad_neg = 1'b1;
    end else if (th_c < 270) begin
      x_c      = th_c - 180;
      quad_neg = 1'b1;
    end else begin
      x_c      = 360 - th_c;
      quad_neg = 1'b0;
    end
    q_c   = (ROM_DEPTH * x_c) / 90;
    idx_c = (q_c > ROM_DEPTH - 1) ? AW'(ROM_DEPTH - 1) : AW'(q_c);
  end

  always_comb begin
    mag_c = DATA_W'(rom_data);
    val_c = neg_q ? ((~mag_c) + DATA_W'(1)) : mag_c;
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    w_d          = w_q;
    theta_d      = theta_q;
    neg_d        = neg_q;
    rom_en_d     = 1'b0;
    rom_addr_d   = rom_addr_q;
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    req_ready_c  = '0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          req_ready_c[win_idx] = 1'b1;
          w_d     = win_idx;
          theta_d = theta_new;
          state_d = NORM;
        end
      end
      NORM: begin
        if (theta_q >= DEG360) begin
          theta_d = theta_q - DEG360;
        end else if (theta_q[TW-1]) begin
          theta_d = theta_q + DEG360;
        end else begin
          rom_en_d   = 1'b1;
          rom_addr_d = idx_c;
          neg_d      = quad_neg;
          state_d    = READ;
        end
      end
      READ: state_d = WAIT;
      WAIT: begin
        resp_data_d[w_q*DATA_W +: DATA_W] = val_c;
        resp_valid_d[w_q] = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        last_d  = w_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= GW'(NUM_REQ - 1);
      w_q          <= '0;
      theta_q      <= '0;
      neg_q        <= 1'b0;
      rom_en_q     <= 1'b0;
      rom_addr_q   <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      w_q          <= w_d;
      theta_q      <= theta_d;
      neg_q        <= neg_d;
      rom_en_q     <= rom_en_d;
      rom_addr_q   <= rom_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign rom_en         = rom_en_q;
  assign rom_addr       = rom_addr_q;

endmodule

// File: tb/tb_trig_rom_arbiter.sv
// Directed bench for trig_rom_arbiter with a rom[i] = i + 100 ROM model.
module tb_trig_rom_arbiter;

  logic       clk;
  logic       rst_n;
  logic       rom_en;
  logic [5:0] rom_addr;
  logic [7:0] rom_data;

  int n_checks;
  int n_fail;

  trig_rom_arbiter_if #(.NUM_REQ(3), .ANGLE_W(16), .DATA_W(16)) bus ();

  trig_rom_arbiter #(
    .NUM_REQ(3), .ANGLE_W(16), .ROM_DEPTH(64), .ROM_WIDTH(8), .DATA_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_en) rom_data <= 8'(32'(rom_addr) + 100);
  end

  typedef struct {
    int          lane;
    logic        func;
    logic [15:0] angle;
    logic [15:0] exp_data;
    int          exp_lat;
    logic [5:0]  exp_addr;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_req(input int lane, input logic f, input logic [15:0] ang,
                        output int lat, output logic [15:0] data,
                        output logic [5:0] addr, output int en_cnt, output logic stray);
    int guard;
    lat = 0; data = '0; addr = '0; en_cnt = 0; stray = 1'b0;
    @(negedge clk);
    bus.req_valid[lane] = 1'b1;
    bus.req_func[lane]  = f;
    bus.req_angle[lane*16 +: 16] = ang;
    #1;
    guard = 0;
    while (!bus.req_ready[lane] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready[lane]) begin
      bus.req_valid[lane] = 1'b0;
      lat = -1;
      return;
    end
    @(negedge clk);
    bus.req_valid[lane] = 1'b0;
    lat = 1;
    while (lat < 300) begin
      if (rom_en) begin
        en_cnt++;
        addr = rom_addr;
      end
      if (bus.resp_valid != 3'b000) begin
        if (bus.resp_valid != 3'(1 << lane)) stray = 1'b1;
        if (bus.resp_valid[lane]) begin
          data = bus.resp_data[lane*16 +: 16];
          break;
        end
      end
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, en_cnt;
    logic [15:0] data;
    logic [5:0]  addr;
    logic        stray;
    int          exp_order[5];
    logic [15:0] rr_exp[3];
    int          g, last_cyc, busy_until, onehot_bad, busy_bad, resp_cnt, rv_seen, en_seen;
    int          gl;
    logic [15:0] lane2_val;

    n_checks = 0;
    n_fail   = 0;
    bus.req_valid = '0;
    bus.req_func  = '0;
    bus.req_angle = '0;
    rst_n = 1'b0;

    vecs[0]  = '{0, 1'b0, 16'd0,     16'd100,   4,  6'd0};
    vecs[1]  = '{1, 1'b0, 16'd180,   16'hFF9C,  4,  6'd0};
    vecs[2]  = '{2, 1'b0, 16'd90,    16'hFF5D,  4,  6'd63};
    vecs[3]  = '{0, 1'b1, 16'd30,    16'd142,   5,  6'd42};
    vecs[4]  = '{1, 1'b0, 16'h7FFF,  16'd104,   95, 6'd4};
    vecs[5]  = '{2, 1'b0, 16'd360,   16'd100,   5,  6'd0};
    vecs[6]  = '{0, 1'b0, 16'd270,   16'd163,   4,  6'd63};
    vecs[7]  = '{1, 1'b0, 16'hFFA6,  16'd163,   5,  6'd63};
    vecs[8]  = '{2, 1'b1, 16'd90,    16'd100,   4,  6'd0};
    vecs[9]  = '{0, 1'b0, 16'd45,    16'd132,   4,  6'd32};
    vecs[10] = '{1, 1'b0, 16'd135,   16'hFF7C,  4,  6'd32};
    vecs[11] = '{2, 1'b0, 16'd225,   16'hFF7C,  4,  6'd32};
    vecs[12] = '{0, 1'b1, 16'd0,     16'd163,   5,  6'd63};
    vecs[13] = '{1, 1'b0, 16'h8000,  16'd105,   96, 6'd5};

    repeat (2) @(negedge clk);
    chk("reset_req_ready",  32'(bus.req_ready),  32'h0);
    chk("reset_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("reset_resp_data",  32'(bus.resp_data[31:0]), 32'h0);
    chk("reset_resp_data2", 32'(bus.resp_data[47:32]), 32'h0);
    chk("reset_rom_en",     32'(rom_en),   32'h0);
    chk("reset_rom_addr",   32'(rom_addr), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      do_req(vecs[i].lane, vecs[i].func, vecs[i].angle, lat, data, addr, en_cnt, stray);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_rom_addr", i), 32'(addr), 32'(vecs[i].exp_addr));
      chk($sformatf("vec%0d_rom_en_count", i), 32'(en_cnt), 32'd1);
      chk($sformatf("vec%0d_stray_resp", i), 32'(stray), 32'd0);
    end

    // All three lanes held valid: expect grants 0,1,2,0,1 five cycles apart.
    reset_dut();
    exp_order = '{0, 1, 2, 0, 1};
    rr_exp    = '{16'd100, 16'd132, 16'hFF9C};
    @(negedge clk);
    bus.req_func  = 3'b000;
    bus.req_angle = {16'd180, 16'd45, 16'd0};
    bus.req_valid = 3'b111;
    #1;
    g = 0; last_cyc = 0; busy_until = -1; onehot_bad = 0; busy_bad = 0; resp_cnt = 0;
    for (int cyc = 0; cyc < 60 && resp_cnt < 5; cyc++) begin
      if (bus.req_ready != 3'b000) begin
        if (!$onehot(bus.req_ready)) onehot_bad++;
        if (cyc <= busy_until) busy_bad++;
        gl = bus.req_ready[0] ? 0 : (bus.req_ready[1] ? 1 : 2);
        if (g < 5) begin
          chk($sformatf("rr_grant%0d_lane", g), 32'(gl), 32'(exp_order[g]));
          if (g > 0) chk($sformatf("rr_grant%0d_gap", g), 32'(cyc - last_cyc), 32'd5);
        end
        last_cyc = cyc;
        busy_until = cyc + 4;
        g++;
      end
      if (bus.resp_valid != 3'b000) begin
        gl = bus.resp_valid[0] ? 0 : (bus.resp_valid[1] ? 1 : 2);
        chk($sformatf("rr_resp%0d_data", resp_cnt), 32'(bus.resp_data[gl*16 +: 16]), 32'(rr_exp[gl]));
        resp_cnt++;
      end
      @(negedge clk);
      if (g >= 5) bus.req_valid = 3'b000;
    end
    chk("rr_grant_count", 32'(g), 32'd5);
    chk("rr_resp_count", 32'(resp_cnt), 32'd5);
    chk("rr_ready_onehot_violations", 32'(onehot_bad), 32'd0);
    chk("rr_ready_while_busy", 32'(busy_bad), 32'd0);

    // Reset during NORM of cos 720: request dropped, outputs cleared at once.
    @(negedge clk);
    bus.req_func[0] = 1'b0;
    bus.req_angle[15:0] = 16'd720;
    bus.req_valid[0] = 1'b1;
    #1;
    chk("midrst_ready_before", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = 3'b000;
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready",  32'(bus.req_ready),  32'h0);
    chk("midrst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("midrst_resp_data",  32'(bus.resp_data[31:0]), 32'h0);
    chk("midrst_resp_data2", 32'(bus.resp_data[47:32]), 32'h0);
    chk("midrst_rom_en",     32'(rom_en),   32'h0);
    chk("midrst_rom_addr",   32'(rom_addr), 32'h0);
    rv_seen = 0; en_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.resp_valid != 3'b000) rv_seen++;
      if (rom_en) en_seen++;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.resp_valid != 3'b000) rv_seen++;
      if (rom_en) en_seen++;
    end
    chk("midrst_no_resp_valid", 32'(rv_seen), 32'd0);
    chk("midrst_no_rom_en", 32'(en_seen), 32'd0);
    do_req(0, 1'b0, 16'd720, lat, data, addr, en_cnt, stray);
    chk("reissue720_latency", 32'(lat), 32'd6);
    chk("reissue720_data", 32'(data), 32'd100);
    chk("reissue720_rom_addr", 32'(addr), 32'd0);

    // Lane 2 keeps its result while lanes 0 and 1 alternate.
    do_req(2, 1'b0, 16'd90, lat, data, addr, en_cnt, stray);
    lane2_val = 16'hFF5D;
    chk("lane2_seed_data", 32'(data), 32'(lane2_val));
    do_req(0, 1'b0, 16'd45, lat, data, addr, en_cnt, stray);
    chk("alt_l0_a_data", 32'(data), 32'd132);
    chk("alt_l0_a_lane2", 32'(bus.resp_data[47:32]), 32'(lane2_val));
    do_req(1, 1'b0, 16'd135, lat, data, addr, en_cnt, stray);
    chk("alt_l1_a_data", 32'(data), 32'hFF7C);
    chk("alt_l1_a_lane0", 32'(bus.resp_data[15:0]), 32'd132);
    chk("alt_l1_a_lane2", 32'(bus.resp_data[47:32]), 32'(lane2_val));
    do_req(0, 1'b0, 16'd180, lat, data, addr, en_cnt, stray);
    chk("alt_l0_b_data", 32'(data), 32'hFF9C);
    chk("alt_l0_b_lane1", 32'(bus.resp_data[31:16]), 32'hFF7C);
    do_req(1, 1'b0, 16'd0, lat, data, addr, en_cnt, stray);
    chk("alt_l1_b_data", 32'(data), 32'd100);
    chk("alt_l1_b_lane0", 32'(bus.resp_data[15:0]), 32'hFF9C);
    chk("alt_l1_b_lane2", 32'(bus.resp_data[47:32]), 32'(lane2_val));

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
